// File: rtl/slot_release_ctrl.sv
// rtl/slot_release_ctrl.sv - exit-side slot release: occupancy bitmap, password/slot checks, timed exit gate
// Optional SLOT_EXIT_STATS_EN adds saturating exit_count / err_count outputs.
module slot_release_ctrl #(
    parameter int N           = 16,
    parameter int GATE_CYCLES = 8,
    localparam int FW         = $clog2(N) + 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          exit_req,
    output logic          exit_ready,
    input  logic          pwd_flag,
    input  logic [FW-1:0] flat_number,
    input  logic          occ_set,
    input  logic [FW-1:0] occ_set_idx,
    output logic          gate_open,
    output logic          exit_done,
    output logic          exit_ok,
    output logic [1:0]    exit_err,
    output logic [N:0]    occupancy,
    output logic [FW:0]   free_count
`ifdef SLOT_EXIT_STATS_EN
    ,
    output logic [15:0]   exit_count,
    output logic [7:0]    err_count
`endif
);

    localparam int CW = (GATE_CYCLES > 1) ? $clog2(GATE_CYCLES + 1) : 1;
    localparam logic [FW-1:0] N_IDX = FW'(N);
    localparam logic [FW:0]   SLOTS = (FW + 1)'(N + 1);

    localparam logic [1:0] ERR_NONE  = 2'b00;
    localparam logic [1:0] ERR_PWD   = 2'b01;
    localparam logic [1:0] ERR_EMPTY = 2'b10;
    localparam logic [1:0] ERR_RANGE = 2'b11;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CHECK = 2'd1,
        OPEN  = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t        state_q, state_nxt;
    logic [FW-1:0] flat_q;
    logic          pwd_q;
    logic [CW-1:0] cnt_q, cnt_nxt;
    logic [N:0]    occ_q, occ_nxt;
    logic [FW:0]   free_q;
    logic [1:0]    res_err_q;
    logic [1:0]    chk_err;
    logic [1:0]    done_err;
    logic          gate_q, done_q, ok_q;
    logic [1:0]    err_q;

    function automatic logic [FW:0] count_ones(input logic [N:0] v);
        logic [FW:0] c;
        c = '0;
        for (int k = 0; k <= N; k++) begin
            c = c + {{FW{1'b0}}, v[k]};
        end
        return c;
    endfunction

    // Check priority: range first so the bitmap is never indexed out of bounds.
    always_comb begin
        chk_err = ERR_NONE;
        if (flat_q > N_IDX) begin
            chk_err = ERR_RANGE;
        end else if (!pwd_q) begin
            chk_err = ERR_PWD;
        end else if (!occ_q[flat_q]) begin
            chk_err = ERR_EMPTY;
        end
    end

    always_comb begin
        state_nxt = state_q;
        cnt_nxt   = cnt_q;
        case (state_q)
            IDLE: begin
                if (exit_req) begin
                    state_nxt = CHECK;
                end
            end
            CHECK: begin
                if (chk_err != ERR_NONE) begin
                    state_nxt = DONE;
                end else begin
                    state_nxt = OPEN;
                    cnt_nxt   = CW'(GATE_CYCLES - 1);
                end
            end
            OPEN: begin
                if (cnt_q == '0) begin
                    state_nxt = DONE;
                end else begin
                    cnt_nxt = cnt_q - 1'b1;
                end
            end
            DONE: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // A same-cycle set from the entry path overrides the release clear.
    always_comb begin
        occ_nxt = occ_q;
        if (state_q == CHECK && chk_err == ERR_NONE) begin
            occ_nxt[flat_q] = 1'b0;
        end
        if (occ_set && occ_set_idx <= N_IDX) begin
            occ_nxt[occ_set_idx] = 1'b1;
        end
    end

    assign done_err = (state_q == CHECK) ? chk_err : res_err_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            flat_q    <= '0;
            pwd_q     <= 1'b0;
            cnt_q     <= '0;
            occ_q     <= '0;
            free_q    <= SLOTS;
            res_err_q <= ERR_NONE;
            gate_q    <= 1'b0;
            done_q    <= 1'b0;
            ok_q      <= 1'b0;
            err_q     <= ERR_NONE;
        end else begin
            if (state_q == IDLE && exit_req) begin
                flat_q <= flat_number;
                pwd_q  <= pwd_flag;
            end
            if (state_q == CHECK) begin
                res_err_q <= chk_err;
            end
            cnt_q  <= cnt_nxt;
            occ_q  <= occ_nxt;
            free_q <= SLOTS - count_ones(occ_q);
            gate_q <= (state_nxt == OPEN);
            done_q <= (state_nxt == DONE);
            if (state_nxt == DONE) begin
                ok_q  <= (done_err == ERR_NONE);
                err_q <= done_err;
            end
        end
    end

`ifdef SLOT_EXIT_STATS_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            exit_count <= '0;
            err_count  <= '0;
        end else if (state_nxt == DONE) begin
            if (done_err == ERR_NONE) begin
                if (exit_count != 16'hFFFF) begin
                    exit_count <= exit_count + 16'd1;
                end
            end else if (err_count != 8'hFF) begin
                err_count <= err_count + 8'd1;
            end
        end
    end
`endif

    assign exit_ready = (state_q == IDLE);
    assign gate_open  = gate_q;
    assign exit_done  = done_q;
    assign exit_ok    = ok_q;
    assign exit_err   = err_q;
    assign occupancy  = occ_q;
    assign free_count = free_q;

endmodule
